// File: rtl/regfile_param.sv
// ============================================================================
// regfile_param : parametrised register file with clear sweep and busy board
// Rev 1.0 | optional same-cycle write bypass: define REGFILE_BYPASS_EN
// ============================================================================
`default_nettype none

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] read_address_0,
  input  logic [ADDR_W-1:0] read_address_1,
  output logic [DATA_W-1:0] read_data_0,
  output logic [DATA_W-1:0] read_data_1,
  output logic              busy_0,
  output logic              busy_1,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [DEPTH-1:0]    r_busy;
  logic                r_ready;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_wr_zero;
  logic w_rsv_zero;

  assign w_wr_zero  = ZERO_REG && (write_address == '0);
  assign w_rsv_zero = ZERO_REG && (rsv_addr == '0);
  assign ready      = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + c_PTR_ONE;
          if (r_clr_ptr == c_LAST_PTR) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (init_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= '0;
            r_ready   <= 1'b0;
          end else begin
            // Reservation is applied last so it wins over a same-entry write.
            if (write_en && !w_wr_zero) r_busy[write_address] <= 1'b0;
            if (rsv_en && !w_rsv_zero)  r_busy[rsv_addr]      <= 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Array has no reset; the sweep hides stale contents until it zeroes them.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (!init_req && write_en) begin
      r_mem[write_address] <= write_data;
    end
  end

  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] v;
    v = '0;
    if (r_state == ST_READY && !(ZERO_REG && addr == '0)) begin
      v = {r_busy[addr], r_mem[addr]};
`ifdef REGFILE_BYPASS_EN
      if (write_en && !w_wr_zero && addr == write_address) begin
        v = {1'b0, write_data};
      end
`endif
    end
    return v;
  endfunction

  always_comb begin
    {busy_0, read_data_0} = f_read(read_address_0);
    {busy_1, read_data_1} = f_read(read_address_1);
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// tb_regfile_param : directed self-checking bench for regfile_param
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic        init_req;
  logic        ready;
  logic [4:0]  read_address_0;
  logic [4:0]  read_address_1;
  logic [31:0] read_data_0;
  logic [31:0] read_data_1;
  logic        busy_0;
  logic        busy_1;
  logic        write_en;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  int n_cmp = 0;
  int n_err = 0;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_req       (init_req),
    .ready          (ready),
    .read_address_0 (read_address_0),
    .read_address_1 (read_address_1),
    .read_data_0    (read_data_0),
    .read_data_1    (read_data_1),
    .busy_0         (busy_0),
    .busy_1         (busy_1),
    .write_en       (write_en),
    .write_address  (write_address),
    .write_data     (write_data),
    .rsv_en         (rsv_en),
    .rsv_addr       (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    rsv_en   = 1'b0;
    init_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_en      = 1'b1;
    write_address = a;
    write_data    = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] a);
    read_address_0 = a;
    read_address_1 = a;
    #1;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst_n = 1'b0;
    idle();
    read_address_0 = 5'd5;
    read_address_1 = 5'd6;
    write_address  = '0;
    write_data     = '0;
    rsv_addr       = '0;
    tick();
    tick();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {30'd0, busy_1, busy_0}, 32'd0);
    chk("reset_rd0", read_data_0, 32'd0);
    chk("reset_rd1", read_data_1, 32'd0);

    // Release reset between edges, then count the sweep.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("sweep_ready_low", {31'd0, ready}, 32'd0);
    end
    tick();
    chk("sweep_ready_high", {31'd0, ready}, 32'd1);

    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk("post_reset_rd0", read_data_0, 32'd0);
      chk("post_reset_rd1", read_data_1, 32'd0);
    end

    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5);
    chk("wr5_rd0", read_data_0, 32'hDEADBEEF);
    chk("wr5_rd1", read_data_1, 32'hDEADBEEF);

    wr(5'd0, 32'h1);
    rd(5'd0);
    chk("zero_reg_rd", read_data_0, 32'd0);

    // Reservation of entry 7, then a clearing write.
    rd(5'd7);
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    #1;
    chk("rsv7_same_cycle", {31'd0, busy_0}, 32'd0);
    tick();
    idle();
    #1;
    chk("rsv7_busy0", {31'd0, busy_0}, 32'd1);
    chk("rsv7_busy1", {31'd0, busy_1}, 32'd1);
    wr(5'd7, 32'h00000077);
    rd(5'd7);
    chk("wr7_busy", {31'd0, busy_0}, 32'd0);
    chk("wr7_data", read_data_0, 32'h00000077);

    // Reserve and write entry 9 in one cycle.
    rd(5'd9);
    rsv_en        = 1'b1;
    rsv_addr      = 5'd9;
    write_en      = 1'b1;
    write_address = 5'd9;
    write_data    = 32'h00000099;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h00000099;
`else
    exp_byp = 32'h00000000;
`endif
    chk("rsvwr9_same_data", read_data_0, exp_byp);
    chk("rsvwr9_same_busy", {31'd0, busy_0}, 32'd0);
    tick();
    idle();
    #1;
    chk("rsvwr9_busy", {31'd0, busy_0}, 32'd1);
    chk("rsvwr9_data", read_data_1, 32'h00000099);

    // Same-cycle read of a write target.
    wr(5'd3, 32'h33333333);
    rd(5'd3);
    write_en      = 1'b1;
    write_address = 5'd3;
    write_data    = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h33333333;
`endif
    chk("wr3_same_cycle", read_data_0, exp_byp);
    tick();
    idle();
    #1;
    chk("wr3_next_cycle", read_data_1, 32'hA5A5A5A5);

    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    tick();
    idle();
    rd(5'd0);
    chk("zero_reg_busy", {31'd0, busy_0}, 32'd0);

    // Fill, reserve 4, then init_req with a write that must be dropped.
    for (int a = 1; a < 32; a++) wr(5'(a), 32'h01010101 * a);
    rd(5'd17);
    chk("fill_17", read_data_0, 32'h11111111);
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    tick();
    idle();
    rd(5'd4);
    chk("rsv4_busy", {31'd0, busy_0}, 32'd1);
    init_req      = 1'b1;
    write_en      = 1'b1;
    write_address = 5'd12;
    write_data    = 32'hCCCCCCCC;
    tick();
    idle();
    chk("init_ready_low", {31'd0, ready}, 32'd0);
    rd(5'd12);
    chk("init_clear_rd", read_data_0, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("init_sweep_low", {31'd0, ready}, 32'd0);
    end
    tick();
    chk("init_sweep_high", {31'd0, ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk("post_init_rd0", read_data_0, 32'd0);
      chk("post_init_busy", {31'd0, busy_0}, 32'd0);
    end
    rd(5'd12);
    chk("init_write_dropped", read_data_1, 32'd0);

    // Reset asserted at sweep pointer 10 restarts a full sweep.
    wr(5'd20, 32'h20202020);
    rd(5'd20);
    chk("stale_setup", read_data_0, 32'h20202020);
    init_req = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_sweep_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset_stale", read_data_0, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("restart_ready_low", {31'd0, ready}, 32'd0);
    end
    tick();
    chk("restart_ready_high", {31'd0, ready}, 32'd1);
    rd(5'd20);
    chk("restart_rd20", read_data_0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised successor register file: configurable data width and depth, two combinational read ports, one clocked write port, a hardware clear sequencer, and a per-entry busy scoreboard for pending writes. It sits between the decode stage (read ports, reservations) and the writeback stage (write port) of the datapath. It is the default architectural register store for new datapath work.

## Interface
- DATA_W, 32, data width of every entry
- ADDR_W, 5, address width; depth is DEPTH = 2**ADDR_W
- ZERO_REG, 1, when 1 entry 0 always reads zero and ignores writes and reservations
- Clock: single clock `clk`, all state on its rising edge.
- Reset: `rst_n`, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_req  in  1  pulse: restart the clear sweep (honoured only when ready=1)
- ready  out  1  1 when the clear sweep is finished and the port accepts traffic
- read_address_0  in  ADDR_W  read port 0 address
- read_address_1  in  ADDR_W  read port 1 address
- read_data_0  out  DATA_W  port 0 data, combinational
- read_data_1  out  DATA_W  port 1 data, combinational
- busy_0  out  1  scoreboard bit of read_address_0, combinational
- busy_1  out  1  scoreboard bit of read_address_1, combinational
- write_en  in  1  write strobe
- write_address  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- rsv_en  in  1  reserve an entry (set its busy bit)
- rsv_addr  in  ADDR_W  entry to reserve

## Operation
- FSM states: CLEAR, READY. State encoding is free.
- rst_n low: state=CLEAR, clr_ptr=0, all busy bits=0, ready=0. Array contents are not reset asynchronously.
- CLEAR: each cycle write 0 to ram[clr_ptr] and increment clr_ptr. When clr_ptr==DEPTH-1, perform that final write and go to READY. clr_ptr wraps to 0.
- In CLEAR: write_en, rsv_en and init_req are ignored. read_data_* = 0 and busy_* = 0.
- READY with init_req=1: go to CLEAR, clr_ptr=0, all busy bits cleared on the same edge. Any write_en or rsv_en in that cycle is dropped.
- READY write: when write_en=1, ram[write_address]<=write_data and busy[write_address]<=0.
- READY reservation: when rsv_en=1, busy[rsv_addr]<=1.
- Same address in one cycle for both rsv_en and write_en: busy ends at 1 (reservation wins); the data is still written.
- ZERO_REG=1: writes, reservations and clear-sweep writes to entry 0 have no effect on observable state. read_data for address 0 is 0 and busy for address 0 is 0.
- Both read ports may address the same entry; they return identical values.

## Timing
- Reset values: ready=0, busy_0=busy_1=0, read_data_0=read_data_1=0.
- Clear sweep takes DEPTH cycles. ready rises on the DEPTH-th rising edge after rst_n deasserts (32 edges at the defaults). The same timing applies after init_req.
- Write latency: data is visible on the read ports from the cycle after the write edge. Same-cycle visibility is governed by Configuration.
- busy update latency: the new value is visible in the cycle after the rsv_en or write_en edge.
- rst_n asserted mid-sweep or mid-operation: immediately return to CLEAR with ptr=0. Stale data may remain in the array, but it is unobservable until the new sweep zeroes it.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: when state=READY, write_en=1, the write targets an entry other than a hard-wired zero entry, and a read address equals write_address, that read port returns write_data combinationally in the same cycle. busy for that port reads 0, unless rsv_en targets the same address in the same cycle, in which case it reads 0 this cycle and 1 from the next cycle.
- Undefined: read ports return the pre-write array contents, and the stored busy bit, during the write cycle.

## Test plan
- Reset release -> ready=0 for 31 edges and ready=1 after the 32nd; reading addresses 0..31 then returns 0x00000000.
- Write 0xDEADBEEF to address 5, then read address 5 on both ports the next cycle -> both ports return 0xDEADBEEF. Write 0x1 to address 0 with ZERO_REG=1 -> address 0 reads 0.
- rsv_en to address 7 -> busy=1 next cycle. Write address 7 -> busy=0 next cycle. rsv_en and write to address 9 in the same cycle -> busy=1 and data updated.
- Write 0xA5A5A5A5 to address 3 while reading address 3 in the same cycle -> 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, otherwise the prior value.
- Fill entries with nonzero values and reserve address 4, then pulse init_req -> ready=0 for 32 cycles, then all entries read 0 and busy for address 4 is 0; a write issued in the init_req cycle is dropped.
- Assert rst_n low at sweep pointer 10 -> ready stays 0, and the sweep restarts with a full 32-cycle duration.
